// File: rtl/uart_ram_pkg.sv
// Shared definitions for the UART-to-RAM command sequencer: state encoding,
// default command bytes and the inter-byte timeout derivation.
package uart_ram_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TO_W    = 32;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ADDR  = 3'd1;
    localparam state_t S_LEN   = 3'd2;
    localparam state_t S_WDATA = 3'd3;
    localparam state_t S_RREQ  = 3'd4;
    localparam state_t S_RWAIT = 3'd5;
    localparam state_t S_RLAT  = 3'd6;
    localparam state_t S_TX    = 3'd7;

    localparam logic [7:0] CMD_WR_DEF = 8'h57;
    localparam logic [7:0] CMD_RD_DEF = 8'h52;

    // Timeout length in clock cycles from the clock frequency in MHz.
    function automatic int unsigned to_cyc(input int unsigned clk_fre,
                                           input int unsigned timeout_us);
        return clk_fre * timeout_us;
    endfunction

endpackage

// File: rtl/uart_ram_timeout.sv
// Clearable inter-byte timeout counter; expire_o is high while the count
// sits at TO_CYC-1 in an enabled state.
module uart_ram_timeout
    import uart_ram_pkg::*;
#(
    parameter int unsigned TO_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] TERM = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            expire_q, expire_d;

    // Count up while enabled, saturating at the terminal value.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q != TERM) begin
            cnt_d = cnt_q + TO_W'(1);
        end
        expire_d = en_i && !clr_i && (cnt_d == TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/uart_ram_ctrl.sv
// Command sequencer between uart_rx, a single-port synchronous RAM and
// uart_tx. Frames: cmd, addr, len, then len payload bytes for writes.
module uart_ram_ctrl
    import uart_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CLK_FRE    = 50,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter logic [7:0]  CMD_WR     = CMD_WR_DEF,
    parameter logic [7:0]  CMD_RD     = CMD_RD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned TO_CYC = to_cyc(CLK_FRE, TIMEOUT_US);

    state_t            state_q, state_d;
    logic              rx_ready_c;
    logic              accept;
    logic              to_en, to_clr, to_expire, to_fire;
    logic              tx_hs;
    logic              is_cmd;

    logic              dir_rd_q, dir_rd_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Receiver is only accepted while parsing the frame header or write payload.
    always_comb begin
        rx_ready_c = 1'b0;
        case (state_q)
            S_IDLE, S_ADDR, S_LEN, S_WDATA: rx_ready_c = 1'b1;
            default:                        rx_ready_c = 1'b0;
        endcase
    end

    assign rx_data_ready = rx_ready_c && rst_n;
    assign accept        = rx_data_valid && rx_data_ready;
    assign to_en         = rx_ready_c && (state_q != S_IDLE);
    assign to_fire       = to_expire && to_en && !accept;
    assign tx_hs         = tx_valid_q && tx_data_ready;
    assign is_cmd        = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign to_clr        = accept || (state_d != state_q);

    uart_ram_timeout #(
        .TO_CYC (TO_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (to_en),
        .clr_i    (to_clr),
        .expire_o (to_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted byte always wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_cmd) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (accept)       state_d = S_LEN;
                else if (to_fire) state_d = S_IDLE;
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0) state_d = S_IDLE;
                    else if (dir_rd_q)   state_d = S_RREQ;
                    else                 state_d = S_WDATA;
                end else if (to_fire) begin
                    state_d = S_IDLE;
                end
            end
            S_WDATA: begin
                if (accept) begin
                    if (cnt_q == 8'd1) state_d = S_IDLE;
                end else if (to_fire) begin
                    state_d = S_IDLE;
                end
            end
            S_RREQ:  state_d = S_RWAIT;
            S_RWAIT: state_d = S_RLAT;
            S_RLAT:  state_d = S_TX;
            S_TX: begin
                if (tx_hs) state_d = (cnt_q == 8'd1) ? S_IDLE : S_RREQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        dir_rd_d    = dir_rd_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_cmd) dir_rd_d = (rx_data == CMD_RD);
                    else        err_d    = 1'b1;
                end
            end
            S_ADDR: begin
                if (accept)       ptr_d = ADDR_W'(rx_data);
                else if (to_fire) err_d = 1'b1;
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0) err_d = 1'b1;
                    else                 cnt_d = rx_data;
                end else if (to_fire) begin
                    err_d = 1'b1;
                end
            end
            S_WDATA: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = ptr_q;
                    ram_wdata_d = rx_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - 8'd1;
                    done_d      = (cnt_q == 8'd1);
                end else if (to_fire) begin
                    err_d = 1'b1;
                end
            end
            S_RREQ: begin
                ram_addr_d = ptr_q;
            end
            S_RLAT: begin
                tx_data_d  = ram_rdata;
                tx_valid_d = 1'b1;
            end
            S_TX: begin
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    ptr_d      = ptr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - 8'd1;
                    done_d     = (cnt_q == 8'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_rd_q    <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dir_rd_q    <= dir_rd_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// Bench for uart_ram_ctrl: directed frames plus randomized write/read
// frames checked against an array model of RAM contents.
module tb_uart_ram_ctrl;

    localparam int unsigned TO_CYC = 40;
    localparam logic [7:0]  CMD_WR = 8'h57;
    localparam logic [7:0]  CMD_RD = 8'h52;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       busy;
    logic       done;
    logic       err;

    uart_ram_ctrl #(
        .ADDR_W     (8),
        .CLK_FRE    (1),
        .TIMEOUT_US (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  pay [256];
    logic        rd_phase = 1'b0;

    // Monitor state, written only by the monitor processes.
    logic [15:0] wr_q [$];
    logic [7:0]  tx_q [$];
    int          cyc = 0;
    int          acc_cyc = -10;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          lat_bad = 0;
    int          stab_bad = 0;
    int          rdy_bad = 0;
    logic        last_done_we = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_q.push_back({ram_addr, ram_wdata});
            if (cyc != acc_cyc + 1) lat_bad++;
        end
        if (rx_data_valid && rx_data_ready) acc_cyc = cyc;
        if (done) begin
            done_cnt++;
            last_done_we = ram_we;
        end
        if (err) err_cnt++;
        if (tx_data_valid && tx_data_ready) tx_q.push_back(tx_data);
        if (rst_n && hold_prev && (!tx_data_valid || tx_data !== hold_data)) stab_bad++;
        hold_prev = rst_n && tx_data_valid && !tx_data_ready;
        hold_data = tx_data;
        if (rd_phase && busy && rx_data_ready) rdy_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data       = b;
        rx_data_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_data_ready) break;
        end
        chk("rx_accept", 32'(k < 200), 32'd1);
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input int n);
        int         wb, d0, e0;
        logic [7:0] ad;
        wb = wr_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(CMD_WR);
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pay[i]);
        settle();
        chk("wr_count", 32'(wr_q.size() - wb), 32'(n));
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            chk("wr_event", 32'(wr_q[wb + i]), 32'({ad, pay[i]}));
            ref_mem[ad] = pay[i];
        end
        chk("wr_done", 32'(done_cnt - d0), 32'd1);
        chk("wr_err", 32'(err_cnt - e0), 32'd0);
        chk("wr_done_with_we", 32'(last_done_we), 32'd1);
        chk("wr_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] a, input int n, input bit rnd_ready);
        int         tb0, d0, e0, r0, got;
        logic [7:0] ad;
        tb0 = tx_q.size();
        d0  = done_cnt;
        e0  = err_cnt;
        r0  = rdy_bad;
        send_byte(CMD_RD);
        send_byte(a);
        send_byte(8'(n));
        rd_phase = 1'b1;
        got = 0;
        for (int k = 0; k < n * 60 + 100; k++) begin
            tx_data_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            if (done_cnt != d0 || err_cnt != e0) begin
                got = 1;
                break;
            end
        end
        rd_phase      = 1'b0;
        tx_data_ready = 1'b0;
        chk("rd_finished", 32'(got), 32'd1);
        chk("rd_count", 32'(tx_q.size() - tb0), 32'(n));
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            chk("rd_byte", 32'(tx_q[tb0 + i]), 32'(ref_mem[ad]));
        end
        chk("rd_done", 32'(done_cnt - d0), 32'd1);
        chk("rd_err", 32'(err_cnt - e0), 32'd0);
        chk("rd_rx_ready_low", 32'(rdy_bad - r0), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        int         n, off, m, e0, d0, wb, got, s0;

        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        tx_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_data_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed write / read-back.
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        do_write(8'h10, 3);
        chk("write_latency", 32'(lat_bad), 32'd0);
        do_read(8'h10, 3, 1'b0);

        // Address wrap.
        pay[0] = 8'h11; pay[1] = 8'h22;
        do_write(8'hFF, 2);
        do_read(8'hFF, 2, 1'b0);

        // Bad command bytes.
        e0 = err_cnt; wb = wr_q.size();
        send_byte(8'h41);
        do b = 8'($urandom_range(0, 255)); while (b == CMD_WR || b == CMD_RD);
        send_byte(b);
        settle();
        chk("badcmd_err", 32'(err_cnt - e0), 32'd2);
        chk("badcmd_busy", 32'(busy), 32'd0);
        chk("badcmd_no_we", 32'(wr_q.size() - wb), 32'd0);

        // Zero length.
        e0 = err_cnt; d0 = done_cnt;
        send_byte(CMD_WR);
        send_byte(8'h20);
        send_byte(8'h00);
        settle();
        chk("len0_err", 32'(err_cnt - e0), 32'd1);
        chk("len0_done", 32'(done_cnt - d0), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);

        // Inter-byte timeout after the address byte.
        e0 = err_cnt; wb = wr_q.size();
        send_byte(CMD_WR);
        send_byte(8'h30);
        got = 0;
        for (int k = 1; k <= int'(TO_CYC) + 20; k++) begin
            @(posedge clk);
            #1;
            if (err) begin
                got = k;
                break;
            end
        end
        chk("timeout_cycle", 32'(got), 32'(TO_CYC));
        chk("timeout_busy", 32'(busy), 32'd0);
        settle();
        chk("timeout_err_once", 32'(err_cnt - e0), 32'd1);
        chk("timeout_no_we", 32'(wr_q.size() - wb), 32'd0);
        pay[0] = 8'h5A;
        do_write(8'h30, 1);
        do_read(8'h30, 1, 1'b0);

        // Byte accepted on the exact cycle the timeout would expire.
        e0 = err_cnt; d0 = done_cnt; wb = wr_q.size();
        send_byte(CMD_WR);
        send_byte(8'h40);
        repeat (TO_CYC - 1) @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h3C);
        settle();
        chk("edge_to_err", 32'(err_cnt - e0), 32'd0);
        chk("edge_to_done", 32'(done_cnt - d0), 32'd1);
        chk("edge_to_write", 32'(wr_q[wb]), 32'h403C);
        ref_mem[8'h40] = 8'h3C;

        // Randomized frames.
        for (int it = 0; it < 8; it++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
            do_write(a, n);
            off = $urandom_range(0, n - 1);
            m   = $urandom_range(1, n - off);
            do_read(a + 8'(off), m, 1'b1);
        end

        // Backpressure: transmitter stalled for 100 cycles.
        e0 = err_cnt; d0 = done_cnt;
        tx_data_ready = 1'b0;
        send_byte(CMD_RD);
        send_byte(8'h10);
        send_byte(8'h03);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (tx_data_valid) begin
                got = 1;
                break;
            end
        end
        chk("bp_valid_seen", 32'(got), 32'd1);
        s0 = stab_bad;
        repeat (100) @(posedge clk);
        #1;
        chk("bp_valid_held", 32'(tx_data_valid), 32'd1);
        chk("bp_data", 32'(tx_data), 32'(ref_mem[8'h10]));
        chk("bp_stable", 32'(stab_bad - s0), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);

        // Reset mid-frame.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_data_ready), 32'd0);
        chk("mid_rst_done_err", 32'({done, err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        chk("post_rst_done", 32'(done_cnt - d0), 32'd0);
        chk("post_rst_err", 32'(err_cnt - e0), 32'd0);
        a = 8'($urandom_range(0, 255));
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
        do_write(a, n);
        do_read(a, n, 1'b1);
        chk("final_latency", 32'(lat_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_ram_ctrl.md
Name: uart_ram_ctrl

Overview:
- Command sequencer between the UART byte receiver and a single-port synchronous RAM.
- Parses framed commands from the received byte stream: cmd, addr, len, then data.
- Write frames store the payload bytes into RAM.
- Read frames fetch bytes from RAM and hand them one at a time to the UART transmitter over a valid/ready handshake.
- Sits between uart_rx (upstream), the RAM (beside it) and uart_tx (downstream).

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- CLK_FRE, 50, clock frequency in MHz; used only to derive the timeout.
- TIMEOUT_US, 1000, inter-byte timeout in microseconds; TO_CYC = CLK_FRE*TIMEOUT_US.
- CMD_WR, 8'h57, write command byte ('W').
- CMD_RD, 8'h52, read command byte ('R').

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- rx_data  in  8  received byte
- rx_data_valid  in  1  received byte valid; held until accepted
- rx_data_ready  out  1  controller accepts rx_data
- ram_we  out  1  RAM write enable, one-cycle pulse per byte
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  8  RAM write data, registered
- ram_rdata  in  8  RAM read data, valid 1 cycle after ram_addr is presented
- tx_data  out  8  byte to transmit
- tx_data_valid  out  1  tx_data valid
- tx_data_ready  in  1  transmitter accepts tx_data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on successful frame completion
- err  out  1  one-cycle pulse on bad command, len==0, or timeout

Behaviour:
- Clock, reset and acceptance:
  - One clock domain, clk. rst_n is asynchronous and active low.
  - All outputs reset to 0. The FSM resets to S_IDLE; counters reset to 0.
  - A byte is accepted in the cycle where rx_data_valid && rx_data_ready.
- rx_data_ready:
  - Driven combinationally from state: 1 in S_IDLE, S_ADDR, S_LEN, S_WDATA; 0 in every other state.
  - While it is 0, uart_rx holds its byte.
- FSM states and transitions:
  - S_IDLE:
    - Accepted byte == CMD_WR or CMD_RD: latch the direction and go to S_ADDR.
    - Accepted byte of any other value: pulse err and stay in S_IDLE.
  - S_ADDR: accepted byte loads the address pointer; go to S_LEN.
  - S_LEN:
    - Accepted byte == 0: pulse err and go to S_IDLE.
    - Nonzero byte: load cnt = byte (1..255). Go to S_WDATA for a write, S_RREQ for a read.
  - S_WDATA:
    - On each accepted byte, in the next cycle: ram_we=1, ram_addr=ptr, ram_wdata=byte. Then ptr<=ptr+1 (wrapping) and cnt<=cnt-1.
    - When the accepted byte is the one with cnt==1: go to S_IDLE and pulse done in the same cycle as the last ram_we.
    - Write latency: one clock from byte acceptance to the ram_we pulse.
  - S_RREQ: drive ram_addr=ptr; go to S_RWAIT.
  - S_RWAIT: one-cycle RAM latency; go to S_RLAT.
  - S_RLAT: tx_data<=ram_rdata, tx_data_valid<=1; go to S_TX.
  - S_TX:
    - Hold tx_data/tx_data_valid stable until tx_data_ready.
    - On handshake: tx_data_valid<=0, ptr<=ptr+1, cnt<=cnt-1.
    - If cnt was 1: pulse done and go to S_IDLE. Otherwise go to S_RREQ.
    - A handshake can occur at most once every 4 cycles.
- Timeout:
  - A 32-bit counter runs in S_ADDR, S_LEN and S_WDATA.
  - It clears on each accepted byte and on every state change.
  - When it reaches TO_CYC-1: pulse err and go to S_IDLE. Partial writes already performed remain in RAM.
  - The counter does not run in read states; the transmitter may stall indefinitely.
- Simultaneous events: a byte accepted in the same cycle the timeout expires counts as accepted. The timeout does not fire and the counter clears.
- busy = (state != S_IDLE).
- ram_we is never asserted outside S_WDATA processing.
- Address wrap: with ptr = 2^ADDR_W-1, the next access goes to address 0.
- Reset mid-frame: immediate return to S_IDLE with all outputs 0. No done or err pulse.

Decomposition:
- Shared package uart_ram_pkg holds:
  - state encoding localparams (S_IDLE..S_TX, 3 bits);
  - CMD_WR and CMD_RD defaults;
  - the TO_CYC derivation.
- One natural sub-module: uart_ram_timeout, a clearable timeout counter with enable, clear and expire outputs.
- The FSM, pointer and count registers stay in uart_ram_ctrl.

Test Plan:
- Write frame 57 10 03 AA BB CC, bytes back-to-back with valid held until ready → ram_we pulses at addresses 0x10/0x11/0x12 with data AA/BB/CC, one done pulse, no err.
- Read frame 52 10 03 after that write, tx_data_ready held high → tx_data sequence AA, BB, CC, each valid until its handshake, then done. rx_data_ready stays 0 throughout the read phase.
- Wrap-around: 57 FF 02 11 22 → writes 11 to address FF and 22 to address 00.
- Error cases:
  - 41 (bad command) → err pulse, still S_IDLE, no RAM activity.
  - 57 20 00 → err pulse after the len byte.
- Timeout: 57 30, then silence for TO_CYC cycles → err pulse at TO_CYC-1, busy goes 0. The next frame 57 30 01 5A parses normally.
- Backpressure and reset: read frame with tx_data_ready low for 100 cycles → tx_data stable and valid held. Then assert rst_n low mid-frame → all outputs 0 immediately, and a fresh frame works afterward.
